// File: rtl/mem_copy_master.sv
// rtl/mem_copy_master.sv - bus initiator copying a block of words between address ranges
module mem_copy_master #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] read_data,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            remaining <= '0;
            data_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        src_q     <= src_addr;
                        dst_q     <= dst_addr;
                        remaining <= count;
                    end
                end
                S_RD_DATA: data_q <= read_data;
                S_WRITE: begin
                    src_q     <= src_q + ADDR_ONE;
                    dst_q     <= dst_q + ADDR_ONE;
                    remaining <= remaining - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Outputs depend only on registered state, never on the inputs directly.
    always_comb begin
        state_d  = state_q;
        mem_cmd  = MNONE;
        mem_addr = '0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (count != '0) ? S_RD_ADDR : S_DONE;
                end
            end
            S_RD_ADDR: begin
                mem_cmd  = MREAD;
                mem_addr = src_q;
                state_d  = S_RD_DATA;
            end
            S_RD_DATA: begin
                mem_cmd  = MREAD;
                mem_addr = src_q;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                mem_cmd  = MWRITE;
                mem_addr = dst_q;
                state_d  = (remaining > CNT_ONE) ? S_RD_ADDR : S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign write_data = data_q;

endmodule
